// File: rtl/run_mon_pkg.sv
// Shared types for the run monitor: FSM states, stop codes and the trace record.
package run_mon_pkg;
    localparam int XLEN_P  = 32;
    localparam int CNT_W_P = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [2:0] STS_NONE     = 3'd0;
    localparam logic [2:0] STS_HALT     = 3'd1;
    localparam logic [2:0] STS_MISALIGN = 3'd2;
    localparam logic [2:0] STS_HANG     = 3'd3;
    localparam logic [2:0] STS_TIMEOUT  = 3'd4;
    localparam logic [2:0] STS_OVERFLOW = 3'd5;

    typedef struct packed {
        logic [XLEN_P-1:0]  pc;
        logic [XLEN_P-1:0]  instr;
        logic [CNT_W_P-1:0] cyc;
    } trace_rec_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry an extra wrap bit so full and empty are distinct.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr, r_rptr;
    logic             w_do_push, w_do_pop;

    // A push into a full FIFO is still taken when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

    assign o_dout  = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
endmodule

// File: rtl/cpu_run_monitor.sv
// Run monitor beside the single-cycle core: traces retirements into a FIFO and ends
// the run on halt PC, misaligned PC, self-loop hang, cycle timeout or trace overflow.
module cpu_run_monitor
    import run_mon_pkg::*;
#(
    parameter int              XLEN       = XLEN_P,
    parameter int              CNT_W      = CNT_W_P,
    parameter int              MAX_CYCLES = 10000,
    parameter logic [XLEN-1:0] HALT_PC    = 'h800,
    parameter int              HANG_LIMIT = 16,
    parameter int              FIFO_DEPTH = 8,
    parameter bit              OVF_STOP   = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start_i,
    input  logic             retire_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  instr_i,
    output logic             trace_valid_o,
    input  logic             trace_ready_i,
    output logic [XLEN-1:0]  trace_pc_o,
    output logic [XLEN-1:0]  trace_instr_o,
    output logic [CNT_W-1:0] trace_cyc_o,
    output logic             running_o,
    output logic             done_o,
    output logic [2:0]       status_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] drop_cnt_o
);
    localparam int HW = $clog2(HANG_LIMIT + 1);

    state_e           r_state, w_state_nx;
    logic             r_running, r_done;
    logic [2:0]       r_status, w_stop_code;
    logic [CNT_W-1:0] r_cyc, r_drop;
    logic [HW-1:0]    r_hang_cnt, w_hang_nx;
    logic [XLEN-1:0]  r_last_pc;
    logic             w_in_run, w_push, w_pop, w_drop, w_stop, w_full, w_empty;
    trace_rec_t       w_rec_in, w_rec_out;

    assign w_in_run  = (r_state == ST_RUN);
    assign w_push    = w_in_run && retire_i;
    assign w_pop     = !w_empty && trace_ready_i;
    assign w_drop    = w_push && w_full && !w_pop;
    assign w_hang_nx = (r_hang_cnt != '0 && pc_i == r_last_pc) ? r_hang_cnt + 1'b1 : HW'(1);
    assign w_rec_in  = '{pc: pc_i, instr: instr_i, cyc: r_cyc};

    sync_fifo #(
        .WIDTH ($bits(trace_rec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_trace_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_rec_in),
        .o_dout  (w_rec_out),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Highest-priority cause wins when several stop conditions coincide.
    always_comb begin
        w_stop_code = STS_NONE;
        if (w_push && pc_i[1:0] != 2'b00)                       w_stop_code = STS_MISALIGN;
        else if (w_push && pc_i == HALT_PC)                     w_stop_code = STS_HALT;
        else if (w_push && w_hang_nx == HW'(HANG_LIMIT))        w_stop_code = STS_HANG;
        else if (w_drop && OVF_STOP)                            w_stop_code = STS_OVERFLOW;
        else if (w_in_run && r_cyc == CNT_W'(MAX_CYCLES - 1))   w_stop_code = STS_TIMEOUT;
    end

    assign w_stop = w_in_run && (w_stop_code != STS_NONE);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:  if (start_i) w_state_nx = ST_RUN;
            ST_RUN:   if (w_stop)  w_state_nx = (w_empty && !w_push) ? ST_DONE : ST_DRAIN;
            ST_DRAIN: if (w_empty) w_state_nx = ST_DONE;
            default:  w_state_nx = ST_DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_status   <= STS_NONE;
            r_cyc      <= '0;
            r_drop     <= '0;
            r_hang_cnt <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_running <= (w_state_nx == ST_RUN);
            r_done    <= (w_state_nx == ST_DONE);
            if (w_in_run && !w_stop)     r_cyc      <= r_cyc + 1'b1;
            if (w_stop)                  r_status   <= w_stop_code;
            if (w_drop && r_drop != '1)  r_drop     <= r_drop + 1'b1;
            if (w_push)                  r_hang_cnt <= w_hang_nx;
        end
    end

    // A zero hang count marks the last PC as not yet seen, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_last_pc <= pc_i;
    end

    assign trace_valid_o = !w_empty;
    assign trace_pc_o    = w_empty ? '0 : w_rec_out.pc;
    assign trace_instr_o = w_empty ? '0 : w_rec_out.instr;
    assign trace_cyc_o   = w_empty ? '0 : w_rec_out.cyc;
    assign running_o     = r_running;
    assign done_o        = r_done;
    assign status_o      = r_status;
    assign cycle_cnt_o   = r_cyc;
    assign drop_cnt_o    = r_drop;
endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: two instances (OVF_STOP 0/1, different timeouts) on shared inputs.
module tb_cpu_run_monitor;
    localparam int          DEPTH = 8;
    localparam int          HANG  = 16;
    localparam logic [31:0] HALT  = 32'h800;
    localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_DONE = 3;

    logic        clk = 1'b0;
    logic        rstn, start, retire, ready;
    logic [31:0] pc, instr;

    logic        a_valid, a_run, a_done, b_valid, b_run, b_done;
    logic [31:0] a_pc, a_instr, a_cyc, a_cycle, a_drop;
    logic [31:0] b_pc, b_instr, b_cyc, b_cycle, b_drop;
    logic [2:0]  a_status, b_status;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, one slot per instance.
    int unsigned p_max [2] = '{40, 20};
    bit          p_ovf [2] = '{1'b0, 1'b1};
    int          m_st [2];
    int unsigned m_cyc [2];
    int unsigned m_drop [2];
    int          m_status [2];
    int          m_hang [2];
    logic [31:0] m_last [2];
    logic [31:0] f_pc [2][DEPTH];
    logic [31:0] f_in [2][DEPTH];
    logic [31:0] f_cy [2][DEPTH];
    int          f_n [2];

    logic [31:0] cap_pc [$];
    logic [31:0] cap_in [$];
    logic [31:0] cap_cy [$];

    always #5 clk = ~clk;

    cpu_run_monitor #(.MAX_CYCLES(40), .OVF_STOP(1'b0)) u_a (
        .clk(clk), .rstn(rstn), .start_i(start), .retire_i(retire), .pc_i(pc), .instr_i(instr),
        .trace_valid_o(a_valid), .trace_ready_i(ready), .trace_pc_o(a_pc), .trace_instr_o(a_instr),
        .trace_cyc_o(a_cyc), .running_o(a_run), .done_o(a_done), .status_o(a_status),
        .cycle_cnt_o(a_cycle), .drop_cnt_o(a_drop)
    );

    cpu_run_monitor #(.MAX_CYCLES(20), .OVF_STOP(1'b1)) u_b (
        .clk(clk), .rstn(rstn), .start_i(start), .retire_i(retire), .pc_i(pc), .instr_i(instr),
        .trace_valid_o(b_valid), .trace_ready_i(ready), .trace_pc_o(b_pc), .trace_instr_o(b_instr),
        .trace_cyc_o(b_cyc), .running_o(b_run), .done_o(b_done), .status_o(b_status),
        .cycle_cnt_o(b_cycle), .drop_cnt_o(b_drop)
    );

    // One clock of the behavioural model, from the inputs presented this cycle.
    task automatic model_step(input int k);
        bit push, pop, drop;
        int hn, code, n0;
        if (!rstn) begin
            m_st[k] = S_IDLE; m_cyc[k] = 0; m_drop[k] = 0; m_status[k] = 0;
            m_hang[k] = 0; f_n[k] = 0;
            return;
        end
        n0   = f_n[k];
        push = (m_st[k] == S_RUN) && retire;
        pop  = ready && (n0 > 0);
        drop = push && (n0 == DEPTH) && !pop;
        hn   = (m_hang[k] > 0 && pc == m_last[k]) ? m_hang[k] + 1 : 1;
        code = 0;
        if (m_st[k] == S_RUN) begin
            if (push && pc[1:0] != 2'b00)        code = 2;
            else if (push && pc == HALT)         code = 1;
            else if (push && hn == HANG)         code = 3;
            else if (drop && p_ovf[k])           code = 5;
            else if (m_cyc[k] == p_max[k] - 1)   code = 4;
        end
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                f_pc[k][i] = f_pc[k][i+1]; f_in[k][i] = f_in[k][i+1]; f_cy[k][i] = f_cy[k][i+1];
            end
            f_n[k]--;
        end
        if (push && !drop) begin
            f_pc[k][f_n[k]] = pc; f_in[k][f_n[k]] = instr; f_cy[k][f_n[k]] = m_cyc[k];
            f_n[k]++;
        end
        if (push) begin m_last[k] = pc; m_hang[k] = hn; end
        if (drop && m_drop[k] != 32'hFFFF_FFFF) m_drop[k]++;
        case (m_st[k])
            S_IDLE:  if (start) m_st[k] = S_RUN;
            S_RUN:   if (code != 0) begin
                         m_status[k] = code;
                         m_st[k] = (n0 == 0 && !push) ? S_DONE : S_DRAIN;
                     end else m_cyc[k]++;
            S_DRAIN: if (n0 == 0) m_st[k] = S_DONE;
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
    endtask

    task automatic tick_cap();
        if (a_valid && ready) begin
            cap_pc.push_back(a_pc); cap_in.push_back(a_instr); cap_cy.push_back(a_cyc);
        end
        tick();
    endtask

    task automatic do_reset();
        rstn = 1'b0; start = 1'b0; retire = 1'b0; ready = 1'b0; pc = '0; instr = '0;
        tick(); tick();
        rstn = 1'b1;
        cap_pc.delete(); cap_in.delete(); cap_cy.delete();
    endtask

    task automatic start_run();
        start = 1'b1; tick_cap(); start = 1'b0;
    endtask

    task automatic wait_done_a(input int max_cyc);
        for (int n = 0; n < max_cyc && !a_done; n++) tick_cap();
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b1; retire = 1'b1; ready = 1'b1; pc = $urandom; instr = $urandom;
        tick(); tick();
        n_cmp++; if ({a_valid, a_run, a_done, a_status} !== 6'd0) begin n_bad++;
            $display("FAIL reset_a_ctrl: got %b want 000000", {a_valid, a_run, a_done, a_status}); end
        n_cmp++; if ({a_pc, a_instr, a_cyc, a_cycle, a_drop} !== 160'd0) begin n_bad++;
            $display("FAIL reset_a_data: got %h want 0", {a_pc, a_instr, a_cyc, a_cycle, a_drop}); end
        n_cmp++; if ({b_valid, b_run, b_done, b_status, b_cycle, b_drop} !== 70'd0) begin n_bad++;
            $display("FAIL reset_b: got %h want 0", {b_valid, b_run, b_done, b_status, b_cycle, b_drop}); end
        // Retires while idle must be ignored.
        rstn = 1'b1; start = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if ({a_valid, a_run, a_cycle} !== 34'd0) begin n_bad++;
            $display("FAIL idle_ignores_retire: got %h want 0", {a_valid, a_run, a_cycle}); end
    endtask

    task automatic test_halt();
        logic [31:0] pcs [4] = '{32'h0, 32'h4, 32'h8, 32'h800};
        logic [31:0] ins [4];
        logic [95:0] got;
        do_reset(); ready = 1'b1; start_run();
        for (int i = 0; i < 4; i++) begin
            retire = 1'b1; pc = pcs[i]; instr = $urandom; ins[i] = instr; tick_cap();
        end
        retire = 1'b0;
        wait_done_a(20);
        n_cmp++; if (cap_pc.size() !== 4) begin n_bad++;
            $display("FAIL halt_count: got %0d want 4", cap_pc.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < cap_pc.size()) ? {cap_pc[i], cap_in[i], cap_cy[i]} : 96'hx;
            n_cmp++; if (got !== {pcs[i], ins[i], 32'(i)}) begin n_bad++;
                $display("FAIL halt_rec%0d: got %h want %h", i, got, {pcs[i], ins[i], 32'(i)}); end
        end
        n_cmp++; if ({a_done, a_run, a_status, a_valid} !== {1'b1, 1'b0, 3'd1, 1'b0}) begin n_bad++;
            $display("FAIL halt_final: got %b want 100010", {a_done, a_run, a_status, a_valid}); end
        n_cmp++; if (a_cycle !== 32'd3) begin n_bad++;
            $display("FAIL halt_cycle_cnt: got %0d want 3", a_cycle); end
    endtask

    task automatic test_hang();
        do_reset(); ready = 1'b1; start_run();
        for (int i = 0; i < 20; i++) begin
            retire = 1'b1; pc = 32'h10; instr = $urandom; tick_cap();
        end
        retire = 1'b0;
        wait_done_a(20);
        n_cmp++; if (cap_pc.size() !== HANG) begin n_bad++;
            $display("FAIL hang_count: got %0d want %0d", cap_pc.size(), HANG); end
        for (int i = 0; i < cap_pc.size(); i++) begin
            n_cmp++; if ({cap_pc[i], cap_cy[i]} !== {32'h10, 32'(i)}) begin n_bad++;
                $display("FAIL hang_rec%0d: got %h want %h", i, {cap_pc[i], cap_cy[i]}, {32'h10, 32'(i)}); end
        end
        n_cmp++; if ({a_done, a_status, a_cycle} !== {1'b1, 3'd3, 32'd15}) begin n_bad++;
            $display("FAIL hang_a_final: got %h want %h", {a_done, a_status, a_cycle}, {1'b1, 3'd3, 32'd15}); end
        n_cmp++; if (b_status !== 3'd3) begin n_bad++;
            $display("FAIL hang_b_status: got %0d want 3", b_status); end
    endtask

    task automatic test_misalign();
        logic [31:0] ins;
        do_reset(); ready = 1'b1; start_run();
        retire = 1'b1; pc = 32'h6; instr = $urandom; ins = instr; tick_cap();
        retire = 1'b0;
        wait_done_a(10);
        n_cmp++; if (cap_pc.size() !== 1) begin n_bad++;
            $display("FAIL misalign_count: got %0d want 1", cap_pc.size()); end
        else begin
            n_cmp++; if ({cap_pc[0], cap_in[0], cap_cy[0]} !== {32'h6, ins, 32'h0}) begin n_bad++;
                $display("FAIL misalign_rec: got %h want %h", {cap_pc[0], cap_in[0], cap_cy[0]}, {32'h6, ins, 32'h0}); end
        end
        n_cmp++; if ({a_done, a_status} !== {1'b1, 3'd2}) begin n_bad++;
            $display("FAIL misalign_status: got %b want 1010", {a_done, a_status}); end
    endtask

    task automatic test_timeout();
        int n;
        do_reset(); ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0; n = 1;
        while (!b_done && n < 40) begin tick(); n++; end
        n_cmp++; if (n !== 21) begin n_bad++;
            $display("FAIL timeout_done_cycle: got %0d want 21", n); end
        n_cmp++; if ({b_status, b_cycle, b_valid} !== {3'd4, 32'd19, 1'b0}) begin n_bad++;
            $display("FAIL timeout_b_final: got %h want %h", {b_status, b_cycle, b_valid}, {3'd4, 32'd19, 1'b0}); end
        n_cmp++; if ({a_run, a_cycle} !== {1'b1, 32'd20}) begin n_bad++;
            $display("FAIL timeout_a_running: got %h want %h", {a_run, a_cycle}, {1'b1, 32'd20}); end
    endtask

    task automatic test_overflow();
        do_reset(); ready = 1'b0; start_run();
        for (int i = 0; i < 10; i++) begin
            retire = 1'b1; pc = 32'h100 + 32'(4 * i); instr = $urandom; tick_cap();
        end
        retire = 1'b0;
        n_cmp++; if (a_drop !== 32'd2) begin n_bad++;
            $display("FAIL ovf_a_drop: got %0d want 2", a_drop); end
        n_cmp++; if ({a_run, a_valid, a_pc, a_cyc} !== {2'b11, 32'h100, 32'h0}) begin n_bad++;
            $display("FAIL ovf_a_head: got %h want %h", {a_run, a_valid, a_pc, a_cyc}, {2'b11, 32'h100, 32'h0}); end
        n_cmp++; if ({b_status, b_drop, b_cycle} !== {3'd5, 32'd1, 32'd8}) begin n_bad++;
            $display("FAIL ovf_b_stop: got %h want %h", {b_status, b_drop, b_cycle}, {3'd5, 32'd1, 32'd8}); end
        n_cmp++; if ({b_run, b_done, b_valid} !== 3'b001) begin n_bad++;
            $display("FAIL ovf_b_drain: got %b want 001", {b_run, b_done, b_valid}); end
        ready = 1'b1;
        for (int i = 0; i < 10; i++) tick_cap();
        n_cmp++; if (cap_pc.size() !== DEPTH) begin n_bad++;
            $display("FAIL ovf_a_count: got %0d want %0d", cap_pc.size(), DEPTH); end
        for (int i = 0; i < cap_pc.size(); i++) begin
            n_cmp++; if (cap_pc[i] !== 32'h100 + 32'(4 * i)) begin n_bad++;
                $display("FAIL ovf_a_rec%0d: got %h want %h", i, cap_pc[i], 32'h100 + 32'(4 * i)); end
        end
        n_cmp++; if ({a_valid, b_done} !== 2'b01) begin n_bad++;
            $display("FAIL ovf_drained: got %b want 01", {a_valid, b_done}); end
    endtask

    task automatic test_back_to_back();
        do_reset(); ready = 1'b0; start_run();
        for (int i = 0; i < DEPTH; i++) begin
            retire = 1'b1; pc = 32'h200 + 32'(4 * i); instr = $urandom; tick_cap();
        end
        // Full FIFO: a push alongside a pop must be accepted.
        pc = 32'h220; ready = 1'b1; tick_cap();
        retire = 1'b0; ready = 1'b0; tick();
        n_cmp++; if ({a_drop, b_drop} !== 64'd0) begin n_bad++;
            $display("FAIL pushpop_no_drop: got %h want 0", {a_drop, b_drop}); end
        n_cmp++; if ({b_run, b_status, a_pc} !== {1'b1, 3'd0, 32'h204}) begin n_bad++;
            $display("FAIL pushpop_head: got %h want %h", {b_run, b_status, a_pc}, {1'b1, 3'd0, 32'h204}); end
        retire = 1'b1; pc = HALT; tick(); retire = 1'b0; tick();
        n_cmp++; if ({a_run, a_done, a_valid, a_status, a_drop} !== {3'b001, 3'd1, 32'd1}) begin n_bad++;
            $display("FAIL halt_full_drain: got %h want %h", {a_run, a_done, a_valid, a_status, a_drop}, {3'b001, 3'd1, 32'd1}); end
        n_cmp++; if (b_status !== 3'd1) begin n_bad++;
            $display("FAIL halt_beats_ovf: got %0d want 1", b_status); end
        rstn = 1'b0; tick();
        n_cmp++; if ({a_valid, a_run, a_done, a_status, a_cycle, a_drop} !== 70'd0) begin n_bad++;
            $display("FAIL middrain_reset_a: got %h want 0", {a_valid, a_run, a_done, a_status, a_cycle, a_drop}); end
        n_cmp++; if ({b_valid, b_run, b_done, b_status, b_cycle, b_drop} !== 70'd0) begin n_bad++;
            $display("FAIL middrain_reset_b: got %h want 0", {b_valid, b_run, b_done, b_status, b_cycle, b_drop}); end
        rstn = 1'b1; tick();
        n_cmp++; if ({a_run, a_valid} !== 2'b00) begin n_bad++;
            $display("FAIL middrain_idle: got %b want 00", {a_run, a_valid}); end
        start_run();
        n_cmp++; if ({a_run, a_cycle} !== {1'b1, 32'd0}) begin n_bad++;
            $display("FAIL restart: got %h want %h", {a_run, a_cycle}, {1'b1, 32'd0}); end
    endtask

    task automatic test_random();
        logic [165:0] got, want;
        bit           has;
        for (int r = 0; r < 6; r++) begin
            do_reset(); start_run();
            for (int c = 0; c < 150 && !(m_st[0] == S_DONE && m_st[1] == S_DONE); c++) begin
                retire = ($urandom_range(0, 3) != 0);
                ready  = (r % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                instr  = $urandom;
                if ($urandom_range(0, (r == 0) ? 40 : 4) == 0) begin
                    case ($urandom_range(0, 39))
                        0:       pc = HALT;
                        1:       pc = 32'h42;
                        default: pc = 32'(4 * $urandom_range(0, 15));
                    endcase
                end
                tick();
                for (int k = 0; k < 2; k++) begin
                    has  = (f_n[k] > 0);
                    want = {has, has ? f_pc[k][0] : 32'h0, has ? f_in[k][0] : 32'h0,
                            has ? f_cy[k][0] : 32'h0, m_st[k] == S_RUN, m_st[k] == S_DONE,
                            3'(m_status[k]), 32'(m_cyc[k]), 32'(m_drop[k])};
                    got  = (k == 0) ? {a_valid, a_pc, a_instr, a_cyc, a_run, a_done, a_status, a_cycle, a_drop}
                                    : {b_valid, b_pc, b_instr, b_cyc, b_run, b_done, b_status, b_cycle, b_drop};
                    n_cmp++; if (got !== want) begin n_bad++;
                        $display("FAIL random_r%0d_c%0d_dut%0d: got %h want %h", r, c, k, got, want); end
                end
            end
        end
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; retire = 1'b0; ready = 1'b0; pc = '0; instr = '0;
        test_reset();
        test_halt();
        test_hang();
        test_misalign();
        test_timeout();
        test_overflow();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule
